// File: rtl/carry_save_adder_y_equal_z.sv
`default_nettype none
// ============================================================================
// Module   : carry_save_adder_y_equal_z
// Purpose  : Registered 3:2 carry-save compressor. Reduces three unsigned
//            operands x, y, z to a sum vector u and a carry vector v such
//            that u + v == x + y + z. y and z share one width.
// Ports    : clk_i    - clock, rising edge
//            rst_i    - synchronous active-high reset
//            valid_i  - operands valid this cycle
//            x_i      - operand x   [X_WIDTH-1:0]
//            y_i      - operand y   [YZ_WIDTH-1:0]
//            z_i      - operand z   [YZ_WIDTH-1:0]
//            u_o      - registered sum (bitwise parity) [W-1:0]
//            v_o      - registered carry, pre-shifted left by one [W:0]
//            valid_o  - u_o/v_o hold a new result
// Revision : 1.0 - initial release
// ============================================================================
module carry_save_adder_y_equal_z #(
   parameter int X_WIDTH  = 9,
   parameter int YZ_WIDTH = 9,
   localparam int W = (X_WIDTH > YZ_WIDTH) ? X_WIDTH : YZ_WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic [X_WIDTH-1:0]  x_i,
   input  logic [YZ_WIDTH-1:0] y_i,
   input  logic [YZ_WIDTH-1:0] z_i,
   output logic [W-1:0]        u_o,
   output logic [W:0]          v_o,
   output logic                valid_o
);

   // Zero-width operands make no sense; stop elaboration outright.
   if (X_WIDTH < 1 || YZ_WIDTH < 1) begin : g_param_check
      $fatal(1, "carry_save_adder_y_equal_z: X_WIDTH and YZ_WIDTH must be >= 1");
   end

   // Operands are unsigned, so widening is plain zero extension.
   logic [W-1:0] w_xe;
   logic [W-1:0] w_ye;
   logic [W-1:0] w_ze;
   logic [W-1:0] w_u;
   logic [W-1:0] w_c;
   logic [W:0]   w_v;

   assign w_xe = W'(x_i);
   assign w_ye = W'(y_i);
   assign w_ze = W'(z_i);

   // Independent full-adder cells: no carry ripples between bit positions,
   // so the combinational depth is a single XOR3/MAJ3 level.
   for (genvar i = 0; i < W; i++) begin : g_fa
      assign w_u[i] = w_xe[i] ^ w_ye[i] ^ w_ze[i];
      assign w_c[i] = (w_xe[i] & w_ye[i]) | (w_xe[i] & w_ze[i]) | (w_ye[i] & w_ze[i]);
   end

   // Carry of bit i has weight 2^(i+1); the extra MSB keeps the top carry.
   assign w_v = {w_c, 1'b0};

   logic [W-1:0] r_u;
   logic [W:0]   r_v;
   logic         r_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_u     <= '0;
         r_v     <= '0;
         r_valid <= 1'b0;
      end else begin
         // Data registers hold when no new operands arrive; only the
         // valid flag drops.
         if (valid_i) begin
            r_u <= w_u;
            r_v <= w_v;
         end
         r_valid <= valid_i;
      end
   end

   assign u_o     = r_u;
   assign v_o     = r_v;
   assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_carry_save_adder_y_equal_z.sv
`default_nettype none
// ============================================================================
// Module   : tb_carry_save_adder_y_equal_z
// Purpose  : Directed and random self-checking bench for the registered 3:2
//            compressor at 9/9 and 12/5 operand widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carry_save_adder_y_equal_z;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;

   // 9/9 instance
   logic [8:0]  x, y, z;
   logic [8:0]  u;
   logic [9:0]  v;
   logic        vo;

   // 12/5 instance
   logic [11:0] x2;
   logic [4:0]  y2, z2;
   logic [11:0] u2;
   logic [12:0] v2;
   logic        vo2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   carry_save_adder_y_equal_z #(.X_WIDTH(9), .YZ_WIDTH(9)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid),
      .x_i     (x),
      .y_i     (y),
      .z_i     (z),
      .u_o     (u),
      .v_o     (v),
      .valid_o (vo)
   );

   carry_save_adder_y_equal_z #(.X_WIDTH(12), .YZ_WIDTH(5)) dut2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid),
      .x_i     (x2),
      .y_i     (y2),
      .z_i     (z2),
      .u_o     (u2),
      .v_o     (v2),
      .valid_o (vo2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [63:0] eu,
                            input logic [63:0] ev, input logic [63:0] evalid);
      check({tag, ".u"},     64'(u),  eu);
      check({tag, ".v"},     64'(v),  ev);
      check({tag, ".valid"}, 64'(vo), evalid);
   endtask

   logic [63:0] exp_sum;
   logic [63:0] exp_sum2;
   logic [8:0]  px, py, pz;

   initial begin
      // Reset held two cycles with live operands and valid asserted.
      rst   = 1'b1;
      valid = 1'b1;
      x = 9'd300; y = 9'd411; z = 9'd77;
      x2 = 12'd4095; y2 = 5'd31; z2 = 5'd31;
      tick();
      check_out("reset1", 0, 0, 0);
      check("reset1.u2", 64'(u2), 0);
      check("reset1.v2", 64'(v2), 0);
      check("reset1.valid2", 64'(vo2), 0);
      tick();
      check_out("reset2", 0, 0, 0);
      check("reset2.valid2", 64'(vo2), 0);

      // Typical vector; 12/5 instance gets its top-of-range vector.
      rst = 1'b0;
      x = 9'd101; y = 9'd99; z = 9'd23;
      tick();
      check_out("typical", 17, 206, 1);
      check("typical.sum", 64'(u) + 64'(v), 223);
      check("wide.u2", 64'(u2), 4095);
      check("wide.v2", 64'(v2), 62);
      check("wide.valid2", 64'(vo2), 1);

      x = 9'd0; y = 9'd0; z = 9'd0;
      tick();
      check_out("zero", 0, 0, 1);

      x = 9'd255; y = 9'd511; z = 9'd102;
      tick();
      check_out("mixed", 358, 510, 1);
      check("mixed.sum", 64'(u) + 64'(v), 868);

      x = 9'd255; y = 9'd255; z = 9'd255;
      tick();
      check_out("equal255", 255, 510, 1);

      x = 9'd511; y = 9'd511; z = 9'd511;
      tick();
      check_out("max", 511, 1022, 1);
      check("max.v9", 64'(v[9]), 1);
      check("max.sum", 64'(u) + 64'(v), 1533);

      // Hold: operands change but valid is low.
      valid = 1'b0;
      x = 9'd1; y = 9'd2; z = 9'd4;
      tick();
      check_out("hold", 511, 1022, 0);

      // Reset wins over valid.
      rst = 1'b1; valid = 1'b1;
      tick();
      check_out("rst_prio", 0, 0, 0);
      rst = 1'b0; valid = 1'b0;
      tick();
      check_out("post_rst_idle", 0, 0, 0);
      valid = 1'b1;
      x = 9'd101; y = 9'd99; z = 9'd23;
      tick();
      check_out("post_rst_first", 17, 206, 1);

      // Back-to-back random triples on both instances.
      for (int i = 0; i < 10000; i++) begin
         x  = 9'($urandom_range(0, 511));
         y  = 9'($urandom_range(0, 511));
         z  = 9'($urandom_range(0, 511));
         x2 = 12'($urandom_range(0, 4095));
         y2 = 5'($urandom_range(0, 31));
         z2 = 5'($urandom_range(0, 31));
         px = x; py = y; pz = z;
         exp_sum  = 64'(x) + 64'(y) + 64'(z);
         exp_sum2 = 64'(x2) + 64'(y2) + 64'(z2);
         tick();
         check("rnd.sum",    64'(u) + 64'(v), exp_sum);
         check("rnd.parity", 64'(u), 64'(px ^ py ^ pz));
         check("rnd.valid",  64'(vo), 1);
         check("rnd.sum2",   64'(u2) + 64'(v2), exp_sum2);
         check("rnd.valid2", 64'(vo2), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
